round_robin_distributor: RTL and testbench
==========================================

// Module: round_robin_distributor
//
// PURPOSE
// - Dispatches a single valid/ready input stream fairly across SIZE output channels.
// - Round-robin order, skipping channels whose enable bit is low.
// - Dual of the arbiters: one producer fanned out to many consumers (worker pools, replicated engines).
// - One-entry registered holding stage; the target channel is fixed when an item is loaded.
//
// PARAMETERS
// - SIZE   4  number of output channels (>=2, any value, need not be a power of two)
// - WIDTH  8  payload width in bits
//
// PORTS
// - clock             in   1                    single clock, rising edge
// - resetn            in   1                    reset; asynchronous assert, active-low
// - channel_enable    in   SIZE                 channels eligible for new items
// - upstream_valid    in   1                    input item valid
// - upstream_ready    out  1                    distributor can accept an item
// - upstream_data     in   WIDTH                input payload
// - downstream_valid  out  SIZE                 one-hot (or zero): held item valid for that channel
// - downstream_ready  in   SIZE                 per-channel consumer ready
// - downstream_data   out  WIDTH                held payload, shared by all channels
// - downstream_index  out  $clog2(SIZE) (min 1) index of the current target channel
//
// BEHAVIOUR
// - State: full flag, target register, pointer register, data register.
// - Reset values: full=0, pointer=0, target=0, data=0.
//   - Outputs at reset: downstream_valid=0, downstream_data=0, downstream_index=0.
// - Downstream handshake:
//   - downstream_valid[i] = full && (target==i).
//   - Fire = full && downstream_ready[target].
//   - While full and not fired: valid, data and index stay stable.
//   - Changes on channel_enable never retarget a held item.
// - Search base:
//   - base = fire ? (target+1 mod SIZE) : pointer.
//   - Candidate = first i in base, base+1, ... (wrapping mod SIZE) with channel_enable[i]=1.
// - upstream_ready = (!full || fire) && (|channel_enable).
//   - Combinational path from downstream_ready is allowed.
// - Accept = upstream_valid && upstream_ready.
//   - Loads data and target=candidate; full=1 next cycle.
//   - Latency 1: the item appears on downstream_valid the cycle after acceptance.
// - Fire without accept: full=0 next cycle.
// - On fire: pointer <= target+1 mod SIZE.
//   - Pointer never advances without a fire.
// - Simultaneous fire and accept:
//   - Back-to-back transfer, full stays 1.
//   - New target is searched from the fired target +1.
//   - Sustains 1 item/cycle when the consumers are ready.
// - No channel enabled:
//   - upstream_ready=0.
//   - An already-held item still drains to its target.
// - Reset asserted mid-transfer: the held item is discarded; all state returns to reset values immediately.
// - Wrap: index SIZE-1 increments to 0, including non-power-of-two SIZE.
//
// TESTING
// - Reset: after resetn deassert, downstream_valid=0, upstream_ready=1 (enable=4'b1111).
// - SIZE=4, enable=1111, all ready, 8 items 0x10..0x17 streamed:
//   - targets 0,1,2,3,0,1,2,3; one item per cycle; data matches order.
// - enable=4'b1010, 4 items: targets 1,3,1,3.
//   - Switching enable to 4'b0100 while an item is held for ch3 still delivers it to ch3; the next item goes to ch2.
// - Backpressure: downstream_ready[1]=0 for 5 cycles with an item held for ch1:
//   - valid[1], data and index stable; upstream_ready=0.
//   - On ready, fire; the next item targets ch2 with no bubble.
// - enable=0: upstream_ready=0 and nothing accepted; setting enable=0001 resumes with target 0.
// - SIZE=3, all enabled: targets 0,1,2,0 (wrap).
//   - resetn pulsed low while full: valid drops immediately; the next item targets ch0.

Source files
------------

// File: rtl/round_robin_distributor.sv
// Round-robin distributor: one valid/ready producer fanned out to SIZE consumers.
// A single registered holding stage; the target channel is fixed when an item is loaded.
module round_robin_distributor #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [SIZE-1:0]          channel_enable,
    input  logic                     upstream_valid,
    output logic                     upstream_ready,
    input  logic [WIDTH-1:0]         upstream_data,
    output logic [SIZE-1:0]          downstream_valid,
    input  logic [SIZE-1:0]          downstream_ready,
    output logic [WIDTH-1:0]         downstream_data,
    output logic [$clog2(SIZE)-1:0]  downstream_index
);
    localparam int IW = $clog2(SIZE);

    logic             full;
    logic [IW-1:0]    target;
    logic [IW-1:0]    pointer;
    logic [WIDTH-1:0] data;

    logic             fire;
    logic             accept;
    logic [IW-1:0]    base;
    logic [IW-1:0]    candidate;

    // Modulo-SIZE increment; SIZE need not be a power of two.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] t);
        return (t == IW'(SIZE - 1)) ? '0 : t + 1'b1;
    endfunction

    // First enabled channel at or after base, wrapping. Scanning from the far end
    // lets the nearest hit overwrite the result last.
    function automatic logic [IW-1:0] first_enabled(input logic [IW-1:0] b,
                                                    input logic [SIZE-1:0] en);
        logic [IW-1:0] res;
        res = '0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            int            idx;
            logic [IW-1:0] idx_l;
            idx = int'(b) + k;
            if (idx >= SIZE) idx = idx - SIZE;
            idx_l = IW'(idx);
            if (en[idx_l]) res = idx_l;
        end
        return res;
    endfunction

    assign fire           = full && downstream_ready[target];
    assign base           = fire ? wrap_inc(target) : pointer;
    assign candidate      = first_enabled(base, channel_enable);
    assign upstream_ready = (!full || fire) && (|channel_enable);
    assign accept         = upstream_valid && upstream_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            full    <= 1'b0;
            target  <= '0;
            pointer <= '0;
            data    <= '0;
        end else begin
            if (accept) begin
                full   <= 1'b1;
                target <= candidate;
                data   <= upstream_data;
            end else if (fire) begin
                full <= 1'b0;
            end
            if (fire) pointer <= wrap_inc(target);
        end
    end

    always_comb begin
        downstream_valid = '0;
        for (int i = 0; i < SIZE; i++)
            downstream_valid[i] = full && (target == IW'(i));
    end

    assign downstream_data  = data;
    assign downstream_index = target;

endmodule

// File: tb/tb_round_robin_distributor.sv
// Directed bench: SIZE=4 instance for ordering/backpressure/enable cases,
// SIZE=3 instance for non-power-of-two wrap and mid-transfer reset.
module tb_round_robin_distributor;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // SIZE=4 instance
    logic       resetn;
    logic [3:0] en_a, dv_a, dr_a;
    logic       uv_a, ur_a;
    logic [7:0] ud_a, dd_a;
    logic [1:0] idx_a;

    // SIZE=3 instance
    logic       resetn_b;
    logic [2:0] en_b, dv_b, dr_b;
    logic       uv_b, ur_b;
    logic [7:0] ud_b, dd_b;
    logic [1:0] idx_b;

    round_robin_distributor #(.SIZE(4), .WIDTH(8)) dut_a (
        .clock(clock), .resetn(resetn), .channel_enable(en_a),
        .upstream_valid(uv_a), .upstream_ready(ur_a), .upstream_data(ud_a),
        .downstream_valid(dv_a), .downstream_ready(dr_a),
        .downstream_data(dd_a), .downstream_index(idx_a)
    );

    round_robin_distributor #(.SIZE(3), .WIDTH(8)) dut_b (
        .clock(clock), .resetn(resetn_b), .channel_enable(en_b),
        .upstream_valid(uv_b), .upstream_ready(ur_b), .upstream_data(ud_b),
        .downstream_valid(dv_b), .downstream_ready(dr_b),
        .downstream_data(dd_b), .downstream_index(idx_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    initial begin
        resetn = 1'b0; resetn_b = 1'b0;
        en_a = 4'b1111; dr_a = 4'b1111; uv_a = 1'b0; ud_a = 8'h00;
        en_b = 3'b111;  dr_b = 3'b111;  uv_b = 1'b0; ud_b = 8'h00;
        repeat (2) @(negedge clock);
        resetn = 1'b1; resetn_b = 1'b1;
        #1;
        chk("rst_valid", int'(dv_a), 0);
        chk("rst_ready", int'(ur_a), 1);
        chk("rst_data",  int'(dd_a), 0);
        chk("rst_index", int'(idx_a), 0);
        chk("rst_valid_b", int'(dv_b), 0);

        // all enabled, all ready: 0x10..0x17 at one per cycle
        @(negedge clock);
        uv_a = 1'b1; ud_a = 8'h10;
        @(posedge clock);
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            chk("s1_valid", int'(dv_a), 1 << (n % 4));
            chk("s1_data",  int'(dd_a), 'h10 + n);
            chk("s1_index", int'(idx_a), n % 4);
            if (n < 7) ud_a = 8'(8'h11 + n);
            else       uv_a = 1'b0;
            #1;
            if (n < 7) chk("s1_ready", int'(ur_a), 1);
            @(posedge clock);
        end
        @(negedge clock);
        chk("s1_drained", int'(dv_a), 0);

        // enable=1010: targets 1,3,1,3; then retarget attempt while ch3 item held
        en_a = 4'b1010; uv_a = 1'b1; ud_a = 8'h20;
        @(posedge clock);
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            chk("s2_valid", int'(dv_a), (n % 2 == 1) ? 4'b1000 : 4'b0010);
            chk("s2_data",  int'(dd_a), 'h20 + n);
            chk("s2_index", int'(idx_a), (n % 2 == 1) ? 3 : 1);
            if (n < 3) ud_a = 8'(8'h21 + n);
            else begin
                dr_a = 4'b0111; en_a = 4'b0100; ud_a = 8'h24;
            end
            #1;
            if (n == 3) chk("s2_stall_ready", int'(ur_a), 0);
            @(posedge clock);
        end
        @(negedge clock);
        chk("s2_held_valid", int'(dv_a), 4'b1000);
        chk("s2_held_index", int'(idx_a), 3);
        chk("s2_held_data",  int'(dd_a), 'h23);
        dr_a = 4'b1111;
        #1 chk("s2_release_ready", int'(ur_a), 1);
        @(posedge clock);
        @(negedge clock);
        chk("s2_next_valid", int'(dv_a), 4'b0100);
        chk("s2_next_data",  int'(dd_a), 'h24);
        chk("s2_next_index", int'(idx_a), 2);
        uv_a = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("s2_drained", int'(dv_a), 0);

        // backpressure on ch1 (pointer is at 3 here)
        en_a = 4'b1111; dr_a = 4'b1101; uv_a = 1'b1; ud_a = 8'h30;
        @(posedge clock);
        @(negedge clock);
        chk("s3_idx_first", int'(idx_a), 3);
        ud_a = 8'h31;
        @(posedge clock);
        @(negedge clock);
        chk("s3_idx_second", int'(idx_a), 0);
        ud_a = 8'h32;
        @(posedge clock);
        @(negedge clock);
        ud_a = 8'h33;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("s3_hold_valid", int'(dv_a), 4'b0010);
            chk("s3_hold_data",  int'(dd_a), 'h32);
            chk("s3_hold_index", int'(idx_a), 1);
            chk("s3_hold_ready", int'(ur_a), 0);
            @(posedge clock);
            @(negedge clock);
        end
        dr_a = 4'b1111;
        #1 chk("s3_release_ready", int'(ur_a), 1);
        @(posedge clock);
        @(negedge clock);
        chk("s3_next_valid", int'(dv_a), 4'b0100);
        chk("s3_next_data",  int'(dd_a), 'h33);
        uv_a = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("s3_drained", int'(dv_a), 0);

        // no channel enabled, then enable only ch0
        en_a = 4'b0000; uv_a = 1'b1; ud_a = 8'h40;
        #1 chk("s4_ready_off", int'(ur_a), 0);
        @(posedge clock);
        @(negedge clock);
        chk("s4_none_a", int'(dv_a), 0);
        @(posedge clock);
        @(negedge clock);
        chk("s4_none_b", int'(dv_a), 0);
        en_a = 4'b0001;
        #1 chk("s4_ready_on", int'(ur_a), 1);
        @(posedge clock);
        @(negedge clock);
        chk("s4_valid", int'(dv_a), 4'b0001);
        chk("s4_index", int'(idx_a), 0);
        chk("s4_data",  int'(dd_a), 'h40);
        uv_a = 1'b0;
        @(posedge clock);

        // SIZE=3 wrap: targets 0,1,2,0,1; last item stalls then reset
        @(negedge clock);
        uv_b = 1'b1; ud_b = 8'h50;
        @(posedge clock);
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk("s5_valid", int'(dv_b), 1 << (n % 3));
            chk("s5_index", int'(idx_b), n % 3);
            chk("s5_data",  int'(dd_b), 'h50 + n);
            if (n < 4) ud_b = 8'(8'h51 + n);
            else begin
                uv_b = 1'b0; dr_b = 3'b000;
            end
            @(posedge clock);
        end
        @(negedge clock);
        chk("s5_stalled", int'(dv_b), 3'b010);
        #2 resetn_b = 1'b0;
        #1;
        chk("s5_rst_valid", int'(dv_b), 0);
        chk("s5_rst_data",  int'(dd_b), 0);
        #1 resetn_b = 1'b1;
        uv_b = 1'b1; ud_b = 8'h55; dr_b = 3'b111;
        @(posedge clock);
        @(negedge clock);
        chk("s5_after_valid", int'(dv_b), 3'b001);
        chk("s5_after_index", int'(idx_b), 0);
        chk("s5_after_data",  int'(dd_b), 'h55);
        uv_b = 1'b0;
        @(posedge clock);
        @(negedge clock);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
